// File: rtl/scmp_dly_seq.sv
// scmp_dly_seq -- multi-cycle sequencer for the SC/MP DLY instruction.
//
// Takes ownership of the shared 8-bit ALU for the whole delay and counts the
// accumulator and displacement down using DEC operations. With no ALU stalls
// the sequence is busy for exactly 13 + 2*AC + 2*disp + 512*disp cycles and
// leaves the accumulator at 0xFF. Every cycle with a request and no grant
// stretches the delay by one cycle.
//
// Ports:
//   clk_i      in   1  system clock, rising edge
//   rst_n_i    in   1  synchronous active-low reset
//   start_i    in   1  begin a DLY (sampled only while idle)
//   ac_i       in   8  accumulator value at start
//   disp_i     in   8  displacement byte at start (unsigned)
//   alu_req_o  out  1  shared ALU request
//   alu_gnt_i  in   1  ALU grant; a request is consumed on req && gnt
//   alu_op_o   out  4  ALU_OP_DEC (4'h1) while requesting, else ALU_OP_NUL (4'h0)
//   alu_a_o    out  8  ALU A operand (counter being decremented)
//   alu_b_o    out  8  ALU B operand, constant 0x00
//   alu_res_i  in   8  ALU result
//   alu_cy_i   in   1  ALU carry-out; for DEC, 1 when the operand was 0x00
//   busy_o     out  1  sequence in progress
//   done_o     out  1  one-cycle pulse in the final busy cycle
//   ac_o       out  8  final accumulator, valid with done_o and held after
//
// ALU handshake: alu_req_o, alu_op_o and alu_a_o depend only on state and
// registers. An operation completes on the rising edge where alu_req_o and
// alu_gnt_i are both high; alu_res_i/alu_cy_i are captured on that edge.
// Without a grant the request, opcode and operand are held unchanged.

module scmp_dly_seq #(
  parameter int OVH_CYCLES = 11
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [7:0] ac_i,
  input  logic [7:0] disp_i,
  output logic       alu_req_o,
  input  logic       alu_gnt_i,
  output logic [3:0] alu_op_o,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  input  logic [7:0] alu_res_i,
  input  logic       alu_cy_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] ac_o
);

  localparam logic [3:0] ALU_OP_NUL = 4'h0;
  localparam logic [3:0] ALU_OP_DEC = 4'h1;

  // OVH lasts OVH_CYCLES cycles: the counter is loaded with N-1 and the
  // state is left in the cycle where it reads zero.
  localparam logic [3:0] OVH_INIT = 4'(OVH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OVH    = 3'd1,
    S_DEC_AC = 3'd2,
    S_CHK_AC = 3'd3,
    S_DEC_D  = 3'd4,
    S_CHK_D  = 3'd5
  } state_t;

  state_t     r_state;
  logic [7:0] r_acc;
  logic [7:0] r_dcnt;
  logic [3:0] r_ovh;
  logic       r_borrow;
  logic [7:0] r_ac_out;

  logic w_dec_ac;
  logic w_dec_d;

  assign w_dec_ac = (r_state == S_DEC_AC);
  assign w_dec_d  = (r_state == S_DEC_D);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_acc    <= 8'h00;
      r_dcnt   <= 8'h00;
      r_ovh    <= 4'h0;
      r_borrow <= 1'b0;
      r_ac_out <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_acc   <= ac_i;
            r_dcnt  <= disp_i;
            r_ovh   <= OVH_INIT;
            r_state <= S_OVH;
          end
        end
        S_OVH: begin
          if (r_ovh == 4'h0) begin
            r_state <= S_DEC_AC;
          end else begin
            r_ovh <= r_ovh - 4'h1;
          end
        end
        S_DEC_AC: begin
          if (alu_gnt_i) begin
            r_acc    <= alu_res_i;
            r_borrow <= alu_cy_i;
            r_state  <= S_CHK_AC;
            // Final decrement: publish the result so ac_o is already valid
            // in the CHK_AC cycle that carries done_o.
            if (alu_cy_i && (r_dcnt == 8'h00)) begin
              r_ac_out <= alu_res_i;
            end
          end
        end
        S_CHK_AC: begin
          if (!r_borrow) begin
            r_state <= S_DEC_AC;
          end else if (r_dcnt == 8'h00) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DEC_D;
          end
        end
        S_DEC_D: begin
          if (alu_gnt_i) begin
            r_dcnt  <= alu_res_i;
            r_state <= S_CHK_D;
          end
        end
        S_CHK_D: begin
          // acc wrapped to 0xFF on the borrow, so the next AC pass is 256 DECs.
          r_state <= S_DEC_AC;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = (r_state == S_CHK_AC) && r_borrow && (r_dcnt == 8'h00);
  assign ac_o      = r_ac_out;
  assign alu_req_o = w_dec_ac | w_dec_d;
  assign alu_op_o  = (w_dec_ac | w_dec_d) ? ALU_OP_DEC : ALU_OP_NUL;
  assign alu_a_o   = w_dec_ac ? r_acc : (w_dec_d ? r_dcnt : 8'h00);
  assign alu_b_o   = 8'h00;

endmodule

// File: tb/tb_scmp_dly_seq.sv
// Directed bench for scmp_dly_seq. A behavioural ALU answers DEC requests;
// expected operand sequences and busy lengths come from the closed-form
// delay formula computed by hand for each vector.

module tb_scmp_dly_seq;

  localparam logic [3:0] OP_NUL = 4'h0;
  localparam logic [3:0] OP_DEC = 4'h1;
  localparam int         BUSY_LIMIT = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] ac_in;
  logic [7:0] disp_in;
  logic       alu_req;
  logic       alu_gnt;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_res;
  logic       alu_cy;
  logic       busy;
  logic       done;
  logic [7:0] ac_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU: DEC of operand A, borrow when A was zero.
  assign alu_res = alu_a - 8'd1;
  assign alu_cy  = (alu_a == 8'h00);

  scmp_dly_seq #(.OVH_CYCLES(11)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .ac_i      (ac_in),
    .disp_i    (disp_in),
    .alu_req_o (alu_req),
    .alu_gnt_i (alu_gnt),
    .alu_op_o  (alu_op),
    .alu_a_o   (alu_a),
    .alu_b_o   (alu_b),
    .alu_res_i (alu_res),
    .alu_cy_i  (alu_cy),
    .busy_o    (busy),
    .done_o    (done),
    .ac_o      (ac_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Granted operand sequence: AC down to 0, then per displacement step the
  // disp value followed by a full 255..0 pass.
  task automatic build_exp(input logic [7:0] ac, input logic [7:0] disp);
    exp_q.delete();
    for (int v = int'(ac); v >= 0; v--) exp_q.push_back(8'(v));
    for (int d = int'(disp); d >= 1; d--) begin
      exp_q.push_back(8'(d));
      for (int v = 255; v >= 0; v--) exp_q.push_back(8'(v));
    end
  endtask

  // Driver + monitor for one DLY. Called at a negedge; returns at the
  // negedge of the first idle cycle after the sequence.
  task automatic run_seq(input string name, input logic [7:0] ac, input logic [7:0] disp,
                         input int stall_idx, input int stall_len, input int exp_busy);
    int         busy_cnt;
    int         done_cnt;
    int         req_idx;
    int         stall_left;
    int         stall_seen;
    int         bad_op;
    int         bad_stall_a;
    int         mism;
    logic       last_done;
    logic [7:0] ac_done;

    busy_cnt = 0; done_cnt = 0; req_idx = 0; stall_seen = 0;
    bad_op = 0; bad_stall_a = 0; mism = 0; last_done = 1'b0; ac_done = 8'h00;
    stall_left = stall_len;
    got_q.delete();
    build_exp(ac, disp);

    start   = 1'b1;
    ac_in   = ac;
    disp_in = disp;
    alu_gnt = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    ac_in   = 8'($urandom_range(0, 255));
    disp_in = 8'($urandom_range(0, 255));
    @(negedge clk);
    check({name, "/busy_rise"}, busy, 1);

    while (busy && busy_cnt < BUSY_LIMIT) begin
      busy_cnt++;
      last_done = done;
      if (done) begin
        done_cnt++;
        ac_done = ac_out;
      end
      alu_gnt = 1'b1;
      if (alu_req) begin
        if (alu_op !== OP_DEC || alu_b !== 8'h00) bad_op++;
        if (req_idx == stall_idx && stall_left > 0) begin
          alu_gnt = 1'b0;
          stall_left--;
          stall_seen++;
          if (req_idx >= exp_q.size() || alu_a !== exp_q[req_idx]) bad_stall_a++;
        end else begin
          got_q.push_back(alu_a);
          req_idx++;
        end
      end else if (alu_op !== OP_NUL || alu_a !== 8'h00) begin
        bad_op++;
      end
      @(negedge clk);
    end

    check({name, "/timeout"}, (busy_cnt >= BUSY_LIMIT), 0);
    check({name, "/busy_cycles"}, busy_cnt, exp_busy);
    check({name, "/done_count"}, done_cnt, 1);
    check({name, "/done_last"}, last_done, 1);
    check({name, "/ac_at_done"}, ac_done, 8'hFF);
    check({name, "/ac_held"}, ac_out, 8'hFF);
    check({name, "/done_after"}, done, 0);
    check({name, "/dec_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) mism++;
    end
    check({name, "/operands"}, mism, 0);
    check({name, "/op_b_decode"}, bad_op, 0);
    if (stall_len > 0) begin
      check({name, "/stall_cycles"}, stall_seen, stall_len);
      check({name, "/stall_operand"}, bad_stall_a, 0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    alu_gnt = 1'b1;
    ac_in   = 8'h00;
    disp_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/req", alu_req, 0);
    check("rst/op", alu_op, OP_NUL);
    check("rst/a", alu_a, 8'h00);
    check("rst/b", alu_b, 8'h00);
    check("rst/ac_o", ac_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive calls also exercise back-to-back starts right after done.
    run_seq("ac00_d00", 8'h00, 8'h00, -1, 0, 13);
    run_seq("ac05_d00", 8'h05, 8'h00, -1, 0, 23);
    run_seq("ac00_d01", 8'h00, 8'h01, -1, 0, 527);
    run_seq("acff_d02", 8'hFF, 8'h02, -1, 0, 1551);
    run_seq("ac03_stall", 8'h03, 8'h00, 1, 3, 22);
    run_seq("ac80_stall0", 8'h80, 8'h00, 0, 2, 271);

    // Mid-sequence reset: AC=0x10, disp=0x01; DECs fall on busy cycles
    // 12+2j with operand 0x10-j, so cycle 40 is a DEC of 0x02.
    start   = 1'b1;
    ac_in   = 8'h10;
    disp_in = 8'h01;
    alu_gnt = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) begin
        start   = 1'b1;
        ac_in   = 8'h00;
        disp_in = 8'h00;
      end
      if (k == 21) start = 1'b0;
    end
    check("midrst/busy_before", busy, 1);
    check("midrst/req_before", alu_req, 1);
    check("midrst/a_before", alu_a, 8'h02);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst/busy", busy, 0);
    check("midrst/req", alu_req, 0);
    check("midrst/op", alu_op, OP_NUL);
    check("midrst/a", alu_a, 8'h00);
    check("midrst/done", done, 0);
    check("midrst/ac_o", ac_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq("post_rst", 8'h03, 8'h00, -1, 0, 19);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
